// File: rtl/uart_tx_buf.sv
// rtl/uart_tx_buf.sv - buffered 8N1 UART transmitter with a byte FIFO
// A push into an idle, empty buffer is popped on the next edge and framed on the one after.
module uart_tx_buf #(
  parameter int CLK_DIV    = 350,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic                        ser_tx,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        r_state, w_state_nxt;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          r_pend, w_pend_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]    r_bit, w_bit_nxt;
  logic          r_tx, w_tx_nxt;
  logic          w_push, w_pop, w_cnt_last, w_nonempty;
  logic [7:0]    w_head;

  assign in_ready   = ~reset & (r_level != LVL_FULL);
  assign w_push     = in_valid & in_ready;
  assign w_nonempty = (r_level != '0);
  assign w_cnt_last = (r_cnt == CNT_LAST);
  assign w_head     = r_mem[r_rd_ptr];
  assign fifo_level = r_level;
  assign ser_tx     = r_tx;
  assign busy       = (r_state != S_IDLE) | r_pend | w_nonempty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pend  <= 1'b0;
      r_shift <= '0;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  // r_pend marks a byte popped in IDLE whose start bit goes out on the following edge.
  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_tx_nxt    = r_tx;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tx_nxt = 1'b1;
        if (r_pend) begin
          w_state_nxt = S_START;
          w_pend_nxt  = 1'b0;
          w_cnt_nxt   = '0;
          w_tx_nxt    = 1'b0;
        end else if (w_nonempty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_head;
          w_pend_nxt  = 1'b1;
        end
      end
      S_START: begin
        if (w_cnt_last) begin
          w_state_nxt = S_DATA;
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
          w_tx_nxt    = r_shift[0];
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_DATA: begin
        if (w_cnt_last) begin
          w_cnt_nxt = '0;
          if (r_bit == 3'd7) begin
            w_state_nxt = S_STOP;
            w_tx_nxt    = 1'b1;
          end else begin
            w_bit_nxt   = r_bit + 3'd1;
            w_shift_nxt = {1'b0, r_shift[7:1]};
            w_tx_nxt    = r_shift[1];
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_STOP: begin
        if (w_cnt_last) begin
          w_cnt_nxt = '0;
          if (w_nonempty) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_head;
            w_state_nxt = S_START;
            w_tx_nxt    = 1'b0;
          end else begin
            w_state_nxt = S_IDLE;
            w_tx_nxt    = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end
endmodule
